// File: rtl/dsp_ctrl_regs.sv
// Avalon-MM control/status register bank and start/done run-control FSM for the depth core.
// Define DSP_CTRL_CYCLE_CNT_EN to build the run-cycle counter behind CYCLE_CNT (reads 0 otherwise).
module dsp_ctrl_regs #(
  parameter int          WIDTH_ADDR = 8,
  parameter int          WIDTH_DATA = 32,
  parameter int          WIDTH_BE   = 4,
  parameter logic [31:0] ID_VALUE   = 32'h4453_5031
) (
  input  logic                  clk_dsp,
  input  logic                  reset_n,
  input  logic                  avl_write,
  input  logic                  avl_chipselect,
  input  logic [WIDTH_ADDR-1:0] avl_address,
  input  logic [WIDTH_BE-1:0]   avl_byteenable,
  input  logic [WIDTH_DATA-1:0] avl_writedata,
  output logic [WIDTH_DATA-1:0] avl_readdata,
  output logic                  core_start,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic [31:0]           cfg0,
  output logic [31:0]           cfg1,
  output logic                  irq
);

  localparam logic [WIDTH_ADDR-1:0] ADDR_CTRL      = WIDTH_ADDR'(0);
  localparam logic [WIDTH_ADDR-1:0] ADDR_STATUS    = WIDTH_ADDR'(1);
  localparam logic [WIDTH_ADDR-1:0] ADDR_FRAME_CNT = WIDTH_ADDR'(2);
  localparam logic [WIDTH_ADDR-1:0] ADDR_CFG0      = WIDTH_ADDR'(3);
  localparam logic [WIDTH_ADDR-1:0] ADDR_CFG1      = WIDTH_ADDR'(4);
  localparam logic [WIDTH_ADDR-1:0] ADDR_ID        = WIDTH_ADDR'(5);
  localparam logic [WIDTH_ADDR-1:0] ADDR_CYCLE_CNT = WIDTH_ADDR'(6);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic                    start_pulse_reg;
  logic                    start_issue;
  logic                    cont_reg;
  logic                    irq_en_reg;
  logic                    done_reg;
  logic                    ovr_reg;
  logic                    ovr_set;
  logic [31:0]             frame_cnt_reg;
  logic [WIDTH_DATA-1:0]   readdata_reg;
  logic [WIDTH_DATA-1:0]   rd_mux;
  logic [31:0]             cycle_cnt_val;
  logic [WIDTH_BE-1:0][7:0] cfg0_bytes;
  logic [WIDTH_BE-1:0][7:0] cfg1_bytes;

  logic wr_en, rd_en;
  logic sel_ctrl, sel_status, sel_frame, sel_cfg0, sel_cfg1;
  logic start_req, w1c_done, w1c_ovr;

  assign wr_en      = avl_chipselect & avl_write;
  assign rd_en      = avl_chipselect & ~avl_write;
  assign sel_ctrl   = wr_en && (avl_address == ADDR_CTRL);
  assign sel_status = wr_en && (avl_address == ADDR_STATUS);
  assign sel_frame  = wr_en && (avl_address == ADDR_FRAME_CNT);
  assign sel_cfg0   = wr_en && (avl_address == ADDR_CFG0);
  assign sel_cfg1   = wr_en && (avl_address == ADDR_CFG1);
  assign start_req  = sel_ctrl & avl_byteenable[0] & avl_writedata[0];
  assign w1c_done   = sel_status & avl_byteenable[0] & avl_writedata[1];
  assign w1c_ovr    = sel_status & avl_byteenable[0] & avl_writedata[2];

  // Run control: a done in RUN either restarts (CONT or coincident START) or returns to IDLE.
  always_comb begin
    state_next  = state_reg;
    start_issue = 1'b0;
    ovr_set     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_req) begin
          state_next  = RUN;
          start_issue = 1'b1;
        end
      end
      RUN: begin
        if (core_done) begin
          if (cont_reg || start_req) begin
            start_issue = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (start_req) begin
          ovr_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      start_pulse_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      start_pulse_reg <= start_issue;
    end
  end

  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      cont_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
    end else begin
      if (sel_ctrl && avl_byteenable[0]) begin
        cont_reg <= avl_writedata[1];
      end
      if (sel_ctrl && avl_byteenable[1]) begin
        irq_en_reg <= avl_writedata[8];
      end
    end
  end

  // Hardware set takes priority over a software clear landing in the same cycle.
  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      done_reg <= 1'b0;
      ovr_reg  <= 1'b0;
    end else begin
      if (core_done) begin
        done_reg <= 1'b1;
      end else if (w1c_done) begin
        done_reg <= 1'b0;
      end
      if (ovr_set) begin
        ovr_reg <= 1'b1;
      end else if (w1c_ovr) begin
        ovr_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= '0;
    end else if (sel_frame) begin
      frame_cnt_reg <= '0;
    end else if (core_done) begin
      frame_cnt_reg <= frame_cnt_reg + 32'd1;
    end
  end

  for (genvar gi = 0; gi < WIDTH_BE; gi++) begin : g_cfg_lane
    logic [7:0] cfg0_byte_reg;
    logic [7:0] cfg1_byte_reg;

    always_ff @(posedge clk_dsp or negedge reset_n) begin
      if (!reset_n) begin
        cfg0_byte_reg <= '0;
        cfg1_byte_reg <= '0;
      end else if (avl_byteenable[gi]) begin
        if (sel_cfg0) begin
          cfg0_byte_reg <= avl_writedata[gi*8 +: 8];
        end
        if (sel_cfg1) begin
          cfg1_byte_reg <= avl_writedata[gi*8 +: 8];
        end
      end
    end

    assign cfg0_bytes[gi] = cfg0_byte_reg;
    assign cfg1_bytes[gi] = cfg1_byte_reg;
  end

`ifdef DSP_CTRL_CYCLE_CNT_EN
  logic [31:0] run_cnt_reg;
  logic [31:0] cycle_cnt_reg;

  // run_cnt is 0 in the core_start cycle, so the latched value counts start..done inclusive.
  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_reg   <= '0;
      cycle_cnt_reg <= '0;
    end else begin
      if (start_issue) begin
        run_cnt_reg <= '0;
      end else if ((state_reg == RUN) && (run_cnt_reg != 32'hFFFF_FFFF)) begin
        run_cnt_reg <= run_cnt_reg + 32'd1;
      end
      if (core_done) begin
        cycle_cnt_reg <= (run_cnt_reg == 32'hFFFF_FFFF) ? run_cnt_reg : run_cnt_reg + 32'd1;
      end
    end
  end

  assign cycle_cnt_val = cycle_cnt_reg;
`else
  assign cycle_cnt_val = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avl_address)
      ADDR_CTRL: begin
        rd_mux[1] = cont_reg;
        rd_mux[8] = irq_en_reg;
      end
      ADDR_STATUS: begin
        rd_mux[0] = core_busy;
        rd_mux[1] = done_reg;
        rd_mux[2] = ovr_reg;
        rd_mux[4] = (state_reg == RUN);
      end
      ADDR_FRAME_CNT: rd_mux = frame_cnt_reg;
      ADDR_CFG0:      rd_mux = cfg0_bytes;
      ADDR_CFG1:      rd_mux = cfg1_bytes;
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_CYCLE_CNT: rd_mux = cycle_cnt_val;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_dsp or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else if (rd_en) begin
      readdata_reg <= rd_mux;
    end
  end

  assign avl_readdata = readdata_reg;
  assign core_start   = start_pulse_reg;
  assign cfg0         = cfg0_bytes;
  assign cfg1         = cfg1_bytes;
  assign irq          = done_reg & irq_en_reg;

endmodule

// File: tb/tb_dsp_ctrl_regs.sv
// Self-checking bench for dsp_ctrl_regs: directed steps then random traffic against a cycle-level model.
module tb_dsp_ctrl_regs;

  logic        clk_dsp = 1'b0;
  logic        reset_n = 1'b0;
  logic        avl_write = 1'b0;
  logic        avl_chipselect = 1'b0;
  logic [7:0]  avl_address = '0;
  logic [3:0]  avl_byteenable = '0;
  logic [31:0] avl_writedata = '0;
  logic [31:0] avl_readdata;
  logic        core_start;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic [31:0] cfg0;
  logic [31:0] cfg1;
  logic        irq;

  always #5 clk_dsp = ~clk_dsp;

  dsp_ctrl_regs dut (
    .clk_dsp        (clk_dsp),
    .reset_n        (reset_n),
    .avl_write      (avl_write),
    .avl_chipselect (avl_chipselect),
    .avl_address    (avl_address),
    .avl_byteenable (avl_byteenable),
    .avl_writedata  (avl_writedata),
    .avl_readdata   (avl_readdata),
    .core_start     (core_start),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .cfg0           (cfg0),
    .cfg1           (cfg1),
    .irq            (irq)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;

  // Reference model state, kept as plain flags and counts.
  bit          m_run, m_cont, m_irq_en, m_done, m_ovr;
  logic [31:0] m_frame, m_cfg0, m_cfg1, m_rd, m_cyc_latch;
  longint      m_run_from, m_run_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cont = 0; m_irq_en = 0; m_done = 0; m_ovr = 0;
    m_frame = '0; m_cfg0 = '0; m_cfg1 = '0; m_rd = '0; m_cyc_latch = '0;
    m_run_from = 0; m_run_to = 0;
  endtask

  // Cycles elapsed since the last core_start, frozen once the run ends.
  function automatic logic [31:0] run_cnt_now();
    longint v;
    v = (m_run ? longint'(cyc) : m_run_to) - m_run_from;
    if (v > 64'sh0000_0000_FFFF_FFFF) v = 64'sh0000_0000_FFFF_FFFF;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a, input bit busy);
    case (a)
      8'h00: return {23'd0, m_irq_en, 6'd0, m_cont, 1'b0};
      8'h01: return {27'd0, m_run, 1'b0, m_ovr, m_done, busy};
      8'h02: return m_frame;
      8'h03: return m_cfg0;
      8'h04: return m_cfg1;
      8'h05: return 32'h4453_5031;
`ifdef DSP_CTRL_CYCLE_CNT_EN
      8'h06: return m_cyc_latch;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One bus/core cycle: drive, predict, clock, compare.
  task automatic cycle(input bit cs, input bit wr, input logic [7:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input bit done, input bit busy);
    bit          wr_en, rd_en, sreq, start_n, run_n, ovr_hw;
    logic [31:0] rd_n, cnt;
    avl_chipselect = cs; avl_write = wr; avl_address = a; avl_byteenable = be;
    avl_writedata = wd; core_done = done; core_busy = busy;
    wr_en = cs & wr;
    rd_en = cs & ~wr;
    rd_n  = rd_en ? model_read(a, busy) : m_rd;
    sreq  = wr_en && (a == 8'h00) && be[0] && wd[0];
    start_n = 0; run_n = m_run; ovr_hw = 0;
    if (m_run) begin
      if (done) begin
        if (m_cont || sreq) start_n = 1;
        else run_n = 0;
      end else if (sreq) begin
        ovr_hw = 1;
      end
    end else if (sreq) begin
      run_n = 1; start_n = 1;
    end
    if (done) begin
      cnt = run_cnt_now();
      m_cyc_latch = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 1;
    end
    if (wr_en && a == 8'h01 && be[0]) begin
      if (wd[1]) m_done = 0;
      if (wd[2]) m_ovr = 0;
    end
    if (done) m_done = 1;
    if (ovr_hw) m_ovr = 1;
    if (wr_en && a == 8'h02) m_frame = 0;
    else if (done) m_frame = m_frame + 1;
    if (wr_en && a == 8'h00) begin
      if (be[0]) m_cont = wd[1];
      if (be[1]) m_irq_en = wd[8];
    end
    for (int b = 0; b < 4; b++) begin
      if (wr_en && a == 8'h03 && be[b]) m_cfg0[b*8 +: 8] = wd[b*8 +: 8];
      if (wr_en && a == 8'h04 && be[b]) m_cfg1[b*8 +: 8] = wd[b*8 +: 8];
    end
    if (start_n) m_run_from = cyc + 1;
    if (m_run && !run_n) m_run_to = cyc + 1;
    m_run = run_n;
    m_rd  = rd_n;
    @(posedge clk_dsp);
    #1;
    cyc++;
    if (core_start === 1'b1) n_starts++;
    check("core_start", {31'd0, core_start}, {31'd0, start_n});
    check("readdata", avl_readdata, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
    check("cfg0", cfg0, m_cfg0);
    check("cfg1", cfg1, m_cfg1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 4'h0, 32'h0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    cycle(1, 1, a, be, d, 0, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1, 0, a, 4'h0, 32'h0, 0, 0);
  endtask

  task automatic done_pulse();
    cycle(0, 0, 8'h00, 4'h0, 32'h0, 1, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_readdata"}, avl_readdata, 32'h0);
    check({tag, "_core_start"}, {31'd0, core_start}, 32'h0);
    check({tag, "_cfg0"}, cfg0, 32'h0);
    check({tag, "_cfg1"}, cfg1, 32'h0);
    check({tag, "_irq"}, {31'd0, irq}, 32'h0);
  endtask

  int          s0;
  int unsigned asel;
  logic [7:0]  ra;

  initial begin
    model_reset();
    #1;
    check_outputs_zero("reset_init");
    repeat (2) @(posedge clk_dsp);
    #1;
    reset_n = 1'b1;

    // ID and configuration byte lanes
    rd(8'h05);
    check("id_read", avl_readdata, 32'h4453_5031);
    wr(8'h03, 4'b0101, 32'hAABB_CCDD);
    check("cfg0_bytes", cfg0, 32'h00BB_00DD);
    rd(8'h03);
    check("cfg0_readback", avl_readdata, 32'h00BB_00DD);
    wr(8'h04, 4'hF, 32'h1234_5678);
    check("cfg1_full", cfg1, 32'h1234_5678);

    // Single run, done 10 cycles after core_start
    wr(8'h00, 4'hF, 32'h0000_0101);
    check("single_start", {31'd0, core_start}, 32'h1);
    idle(10);
    done_pulse();
    check("single_irq", {31'd0, irq}, 32'h1);
    rd(8'h01);
    check("single_status", avl_readdata, 32'h0000_0002);
    rd(8'h02);
    check("single_frame", avl_readdata, 32'h1);
    rd(8'h06);
`ifdef DSP_CTRL_CYCLE_CNT_EN
    check("single_cycles", avl_readdata, 32'd11);
`else
    check("single_cycles", avl_readdata, 32'd0);
`endif
    check("single_starts", n_starts, 1);
    wr(8'h01, 4'h1, 32'h2);
    check("w1c_irq", {31'd0, irq}, 32'h0);

    // START ignored when lane 0 disabled
    wr(8'h00, 4'b0010, 32'h0000_0101);
    check("start_be0_off", {31'd0, core_start}, 32'h0);

    // Overrun, then START coincident with done
    wr(8'h00, 4'hF, 32'h0000_0101);
    idle(2);
    wr(8'h00, 4'hF, 32'h0000_0101);
    check("overrun_no_start", {31'd0, core_start}, 32'h0);
    rd(8'h01);
    check("overrun_status", avl_readdata, 32'h0000_0014);
    wr(8'h01, 4'h1, 32'h4);
    cycle(1, 1, 8'h00, 4'hF, 32'h0000_0101, 1, 0);
    check("restart_start", {31'd0, core_start}, 32'h1);
    rd(8'h01);
    check("restart_status", avl_readdata, 32'h0000_0012);
    idle(2);
    done_pulse();
    wr(8'h01, 4'h1, 32'h2);

    // Continuous mode: 5 dones give 6 starts
    wr(8'h02, 4'h0, 32'h0);
    s0 = n_starts;
    wr(8'h00, 4'hF, 32'h0000_0103);
    for (int i = 0; i < 5; i++) begin
      idle(3);
      done_pulse();
    end
    idle(1);
    check("cont_starts", n_starts - s0, 6);
    rd(8'h02);
    check("cont_frame", avl_readdata, 32'd5);
    wr(8'h00, 4'hF, 32'h0000_0100);
    idle(2);
    done_pulse();
    rd(8'h01);
    check("cont_stop_status", avl_readdata, 32'h0000_0002);
    check("cont_stop_starts", n_starts - s0, 6);
    wr(8'h01, 4'h1, 32'h2);

    // Collisions
    wr(8'h00, 4'hF, 32'h0000_0101);
    idle(3);
    cycle(1, 1, 8'h01, 4'h1, 32'h2, 1, 0);
    rd(8'h01);
    check("w1c_vs_done", avl_readdata, 32'h0000_0002);
    check("w1c_vs_done_irq", {31'd0, irq}, 32'h1);
    force dut.frame_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt_reg;
    m_frame = 32'hFFFF_FFFF;
    done_pulse();
    rd(8'h02);
    check("frame_wrap", avl_readdata, 32'h0);
    done_pulse();
    cycle(1, 1, 8'h02, 4'hF, 32'h0, 1, 0);
    rd(8'h02);
    check("frame_clear_vs_done", avl_readdata, 32'h0);
    wr(8'h20, 4'hF, 32'hFFFF_FFFF);
    rd(8'h20);
    check("unmapped", avl_readdata, 32'h0);

    // Asynchronous reset in the middle of a run
    rd(8'h05);
    wr(8'h00, 4'hF, 32'h0000_0101);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    model_reset();
    avl_chipselect = 1'b0; avl_write = 1'b0; core_done = 1'b0;
    repeat (2) @(posedge clk_dsp);
    #1;
    reset_n = 1'b1;
    idle(2);
    done_pulse();
    rd(8'h01);
    check("idle_done_status", avl_readdata, 32'h0000_0002);
    rd(8'h02);
    check("idle_done_frame", avl_readdata, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      asel = $urandom_range(0, 8);
      ra = (asel == 8) ? 8'h20 : 8'(asel);
      cycle(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ra, 4'($urandom),
            $urandom, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
